// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM command sequencer: memory MODE codes, FSM states and
// the two-field packet-ID increment used by write bursts.
package tcam_pkg;

  localparam logic [2:0] MODE_I   = 3'b000;
  localparam logic [2:0] MODE_W   = 3'b001;
  localparam logic [2:0] MODE_R   = 3'b010;
  localparam logic [2:0] MODE_F   = 3'b011;
  localparam logic [2:0] MODE_C   = 3'b100;
  localparam logic [2:0] MODE_RST = 3'b101;

  localparam int unsigned MaxBits = 64;

  typedef enum logic [2:0] {
    ModeI   = 3'b000,
    ModeW   = 3'b001,
    ModeR   = 3'b010,
    ModeF   = 3'b011,
    ModeC   = 3'b100,
    ModeRst = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap
  } state_e;

  // Increment the top and bottom idw-bit fields of a bits-wide word independently.
  function automatic logic [MaxBits-1:0] inc_id_fields(input logic [MaxBits-1:0] d,
                                                       input int unsigned bits,
                                                       input int unsigned idw);
    logic [MaxBits-1:0] mask;
    logic [MaxBits-1:0] lo;
    logic [MaxBits-1:0] hi;
    logic [MaxBits-1:0] keep;
    mask = (MaxBits'(1) << idw) - MaxBits'(1);
    lo   = (d + MaxBits'(1)) & mask;
    hi   = (((d >> (bits - idw)) + MaxBits'(1)) & mask) << (bits - idw);
    keep = d & ~(mask | (mask << (bits - idw)));
    return keep | hi | lo;
  endfunction

endpackage

// File: rtl/tcam_rd_capture.sv
// Delays read-beat flags by RdLat cycles, then samples memory read data into a
// one-cycle response pulse.
module tcam_rd_capture #(
  parameter int unsigned Bits  = 8,
  parameter int unsigned RdLat = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_beat,
  input  logic [Bits-1:0] mem_rd_data,
  output logic            rsp_valid,
  output logic [Bits-1:0] rsp_data
);

  logic [RdLat-1:0] beat_q;
  logic             rsp_valid_q;
  logic [Bits-1:0]  rsp_data_q;

  if (RdLat > 1) begin : g_pipe
    always_ff @(posedge clk) begin
      if (rst) beat_q <= '0;
      else     beat_q <= {beat_q[RdLat-2:0], rd_beat};
    end
  end else begin : g_single
    always_ff @(posedge clk) begin
      if (rst) beat_q <= '0;
      else     beat_q <= rd_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= beat_q[RdLat-1];
      if (beat_q[RdLat-1]) rsp_data_q <= mem_rd_data;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: rtl/tcam_cmd_sequencer.sv
// Turns one valid/ready request into the cycle-exact MODE/data/mask/address sequence
// the TCAM expects, with burst auto-increment and read-data capture.
module tcam_cmd_sequencer
  import tcam_pkg::*;
#(
  parameter int unsigned AddressSize = 4,
  parameter int unsigned Bits        = 8,
  parameter int unsigned ID_Width    = 4,
  parameter int unsigned LenWidth    = 5,
  parameter int unsigned RdLat       = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [Bits-1:0]        req_data,
  input  logic [Bits-1:0]        req_mskb,
  input  logic [AddressSize-1:0] req_addr,
  input  logic                   req_dcs,
  input  logic                   req_vbe,
  input  logic                   req_vbi,
  input  logic                   req_inc,
  input  logic [LenWidth-1:0]    req_len,
  output logic [2:0]             mem_mode,
  output logic [Bits-1:0]        mem_data,
  output logic [Bits-1:0]        mem_mskb,
  output logic [AddressSize-1:0] mem_addr,
  output logic                   mem_dcs,
  output logic                   mem_vbe,
  output logic                   mem_vbi,
  output logic [ID_Width-1:0]    mem_pktid,
  input  logic [Bits-1:0]        mem_rd_data,
  output logic                   rsp_valid,
  output logic [Bits-1:0]        rsp_data,
  output logic                   busy
);

  state_e                 state_q, state_d;
  logic                   inc_q, inc_d;
  logic                   dcs_q, dcs_d;
  logic [LenWidth-1:0]    cnt_q, cnt_d;
  logic [2:0]             mode_q, mode_d;
  logic [Bits-1:0]        data_q, data_d;
  logic [Bits-1:0]        mskb_q, mskb_d;
  logic [AddressSize-1:0] addr_q, addr_d;
  logic                   mdcs_q, mdcs_d;
  logic                   vbe_q, vbe_d;
  logic                   vbi_q, vbi_d;
  logic [ID_Width-1:0]    pktid_q, pktid_d;
  logic                   accept;
  logic                   legal_op;

  assign req_ready = (state_q == StIdle);
  assign busy      = ~req_ready;
  assign accept    = req_valid && req_ready;
  assign legal_op  = req_op inside {MODE_W, MODE_R, MODE_F, MODE_C, MODE_RST};

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Illegal ops are accepted but never leave idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && legal_op) state_d = StIssue;
      StIssue: if (cnt_q == '0) state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    inc_d   = inc_q;
    dcs_d   = dcs_q;
    cnt_d   = cnt_q;
    mode_d  = MODE_I;
    data_d  = '0;
    mskb_d  = '0;
    addr_d  = '0;
    mdcs_d  = 1'b0;
    vbe_d   = 1'b0;
    vbi_d   = 1'b0;
    pktid_d = '0;
    unique case (state_q)
      StIdle: begin
        if (accept && legal_op) begin
          inc_d  = req_inc;
          dcs_d  = req_dcs;
          cnt_d  = (req_op == MODE_RST || req_len == '0) ? '0 : req_len - 1'b1;
          mode_d = req_op;
          unique case (req_op)
            MODE_W: begin
              data_d = req_data;
              mskb_d = req_mskb;
              addr_d = req_addr;
              mdcs_d = req_dcs;
              vbe_d  = req_vbe;
              vbi_d  = req_vbi;
            end
            MODE_R: begin
              addr_d = req_addr;
              mdcs_d = req_dcs;
              vbe_d  = req_vbe;
            end
            MODE_C: begin
              data_d = req_data;
              mskb_d = req_mskb;
            end
            MODE_F:  pktid_d = req_data[ID_Width-1:0];
            default: ;
          endcase
        end
      end
      StIssue: begin
        if (cnt_q == '0) begin
          mdcs_d = dcs_q;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          mode_d  = mode_q;
          data_d  = data_q;
          mskb_d  = mskb_q;
          addr_d  = addr_q;
          mdcs_d  = mdcs_q;
          vbe_d   = vbe_q;
          vbi_d   = vbi_q;
          pktid_d = pktid_q;
          unique case (mode_q)
            MODE_W: begin
              addr_d = addr_q + 1'b1;
              if (inc_q) data_d = Bits'(inc_id_fields(MaxBits'(data_q), Bits, ID_Width));
            end
            MODE_R:  addr_d  = addr_q + 1'b1;
            MODE_C:  data_d  = data_q + 1'b1;
            MODE_F:  pktid_d = pktid_q + 1'b1;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q   <= 1'b0;
      dcs_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_I;
      data_q  <= '0;
      mskb_q  <= '0;
      addr_q  <= '0;
      mdcs_q  <= 1'b0;
      vbe_q   <= 1'b0;
      vbi_q   <= 1'b0;
      pktid_q <= '0;
    end else begin
      inc_q   <= inc_d;
      dcs_q   <= dcs_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      mskb_q  <= mskb_d;
      addr_q  <= addr_d;
      mdcs_q  <= mdcs_d;
      vbe_q   <= vbe_d;
      vbi_q   <= vbi_d;
      pktid_q <= pktid_d;
    end
  end

  assign mem_mode  = mode_q;
  assign mem_data  = data_q;
  assign mem_mskb  = mskb_q;
  assign mem_addr  = addr_q;
  assign mem_dcs   = mdcs_q;
  assign mem_vbe   = vbe_q;
  assign mem_vbi   = vbi_q;
  assign mem_pktid = pktid_q;

  tcam_rd_capture #(
    .Bits  (Bits),
    .RdLat (RdLat)
  ) u_rd_capture (
    .clk         (clk),
    .rst         (rst),
    .rd_beat     (mode_q == MODE_R),
    .mem_rd_data (mem_rd_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data)
  );

endmodule

// File: tb/tb_tcam_cmd_sequencer.sv
// Randomized bench for tcam_cmd_sequencer: a request-level model predicts every output
// cycle, and a small memory returns data written earlier by the DUT.
module tb_tcam_cmd_sequencer;

  localparam int AW = 4;
  localparam int B  = 8;
  localparam int IW = 4;
  localparam int LW = 5;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [B-1:0]  req_data;
  logic [B-1:0]  req_mskb;
  logic [AW-1:0] req_addr;
  logic          req_dcs;
  logic          req_vbe;
  logic          req_vbi;
  logic          req_inc;
  logic [LW-1:0] req_len;
  logic [2:0]    mem_mode;
  logic [B-1:0]  mem_data;
  logic [B-1:0]  mem_mskb;
  logic [AW-1:0] mem_addr;
  logic          mem_dcs;
  logic          mem_vbe;
  logic          mem_vbi;
  logic [IW-1:0] mem_pktid;
  logic [B-1:0]  mem_rd_data;
  logic          rsp_valid;
  logic [B-1:0]  rsp_data;
  logic          busy;

  always #5 clk = ~clk;

  tcam_cmd_sequencer #(
    .AddressSize (AW),
    .Bits        (B),
    .ID_Width    (IW),
    .LenWidth    (LW),
    .RdLat       (RL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_data    (req_data),
    .req_mskb    (req_mskb),
    .req_addr    (req_addr),
    .req_dcs     (req_dcs),
    .req_vbe     (req_vbe),
    .req_vbi     (req_vbi),
    .req_inc     (req_inc),
    .req_len     (req_len),
    .mem_mode    (mem_mode),
    .mem_data    (mem_data),
    .mem_mskb    (mem_mskb),
    .mem_addr    (mem_addr),
    .mem_dcs     (mem_dcs),
    .mem_vbe     (mem_vbe),
    .mem_vbi     (mem_vbi),
    .mem_pktid   (mem_pktid),
    .mem_rd_data (mem_rd_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  // Memory stand-in: stores writes, returns mem[addr] one cycle after the address.
  logic [B-1:0] mem_arr [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= '0;
    end else if (mem_mode == 3'b001) begin
      mem_arr[mem_addr] <= mem_data;
    end
    mem_rd_data <= mem_arr[mem_addr];
  end

  typedef struct packed {
    logic [2:0]    mode;
    logic [B-1:0]  data;
    logic [B-1:0]  mskb;
    logic [AW-1:0] addr;
    logic          dcs;
    logic          vbe;
    logic          vbi;
    logic [IW-1:0] pktid;
  } beat_t;

  typedef struct {
    int           cyc;
    logic [B-1:0] data;
  } pulse_t;

  beat_t        exp_q [$];
  pulse_t       pend_q [$];
  logic [B-1:0] shadow [16];
  logic [B-1:0] rsp_hold;
  bit           cur_busy = 1'b0;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [B-1:0] two_field(input logic [B-1:0] d, input int k);
    int hi, lo, mid;
    hi  = ((int'(d) >> (B - IW)) + k) % (1 << IW);
    lo  = ((int'(d) % (1 << IW)) + k) % (1 << IW);
    mid = int'(d) & ((1 << (B - IW)) - 1) & ~((1 << IW) - 1);
    return B'((hi << (B - IW)) | mid | lo);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pend_q.delete();
    rsp_hold = '0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
  endtask

  // Expand the request on the ports into its beats plus the trailing gap cycle.
  task automatic model_accept();
    int    n;
    beat_t b;
    if (!(req_op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5})) return;
    n = (req_op == 3'd5) ? 1 : ((req_len == 0) ? 1 : int'(req_len));
    for (int k = 0; k < n; k++) begin
      b      = '0;
      b.mode = req_op;
      case (req_op)
        3'd1: begin
          b.data = req_inc ? two_field(req_data, k) : req_data;
          b.mskb = req_mskb;
          b.addr = AW'((int'(req_addr) + k) % 16);
          b.dcs  = req_dcs;
          b.vbe  = req_vbe;
          b.vbi  = req_vbi;
        end
        3'd2: begin
          b.addr = AW'((int'(req_addr) + k) % 16);
          b.dcs  = req_dcs;
          b.vbe  = req_vbe;
        end
        3'd4: begin
          b.data = B'((int'(req_data) + k) % 256);
          b.mskb = req_mskb;
        end
        3'd3:    b.pktid = IW'((int'(req_data) % 16 + k) % 16);
        default: ;
      endcase
      exp_q.push_back(b);
    end
    b     = '0;
    b.dcs = req_dcs;
    exp_q.push_back(b);
  endtask

  task automatic check_cycle();
    beat_t e;
    bit    exp_v;
    if (exp_q.size() > 0) begin
      e        = exp_q.pop_front();
      cur_busy = 1'b1;
    end else begin
      e        = '0;
      cur_busy = 1'b0;
    end
    check_eq("mode",  32'(mem_mode),  32'(e.mode));
    check_eq("data",  32'(mem_data),  32'(e.data));
    check_eq("mskb",  32'(mem_mskb),  32'(e.mskb));
    check_eq("addr",  32'(mem_addr),  32'(e.addr));
    check_eq("dcs",   32'(mem_dcs),   32'(e.dcs));
    check_eq("vbe",   32'(mem_vbe),   32'(e.vbe));
    check_eq("vbi",   32'(mem_vbi),   32'(e.vbi));
    check_eq("pktid", 32'(mem_pktid), 32'(e.pktid));
    check_eq("ready", 32'(req_ready), 32'(!cur_busy));
    check_eq("busy",  32'(busy),      32'(cur_busy));
    exp_v = (pend_q.size() > 0) && (pend_q[0].cyc == cyc);
    if (exp_v) begin
      rsp_hold = pend_q[0].data;
      void'(pend_q.pop_front());
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    check_eq("rsp_data",  32'(rsp_data),  32'(rsp_hold));
    if (e.mode == 3'd2) pend_q.push_back('{cyc: cyc + RL + 1, data: shadow[e.addr]});
    if (e.mode == 3'd1) shadow[e.addr] = e.data;
  endtask

  // Inputs currently driven belong to this cycle; the model consumes them, then the
  // bench moves to the next negedge and checks that cycle's outputs.
  task automatic step();
    if (rst) model_reset();
    else if (req_valid && !cur_busy) model_accept();
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic set_req(input logic [2:0] op, input logic [B-1:0] data,
                         input logic [B-1:0] mskb, input logic [AW-1:0] addr,
                         input logic dcs, input logic vbe, input logic vbi,
                         input logic inc, input logic [LW-1:0] len);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    req_mskb  = mskb;
    req_addr  = addr;
    req_dcs   = dcs;
    req_vbe   = vbe;
    req_vbi   = vbi;
    req_inc   = inc;
    req_len   = len;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 64 && (cur_busy || exp_q.size() > 0 || pend_q.size() > 0); i++) step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    set_req(3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    req_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_eq("rst_mode",  32'(mem_mode),  32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_busy",  32'(busy),      32'd0);

    // Single write, gap keeps dcs.
    set_req(3'd1, 8'h00, 8'hFF, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1);
    step();
    req_valid = 1'b0;
    check_eq("w_mode", 32'(mem_mode), 32'd1);
    check_eq("w_mskb", 32'(mem_mskb), 32'hFF);
    check_eq("w_addr", 32'(mem_addr), 32'd1);
    step();
    check_eq("w_gap_mode", 32'(mem_mode), 32'd0);
    check_eq("w_gap_dcs",  32'(mem_dcs),  32'd1);
    check_eq("w_gap_mskb", 32'(mem_mskb), 32'd0);
    step();
    check_eq("w_ready", 32'(req_ready), 32'd1);

    // Read back: pulse two cycles after the issue cycle.
    set_req(3'd2, 8'h00, 8'h00, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
    step();
    req_valid = 1'b0;
    check_eq("r_mode", 32'(mem_mode), 32'd2);
    step();
    check_eq("r_early", 32'(rsp_valid), 32'd0);
    step();
    check_eq("r_pulse", 32'(rsp_valid), 32'd1);
    check_eq("r_data",  32'(rsp_data),  32'h00);
    drain();

    // Write burst with two-field increment and address wrap.
    set_req(3'd1, 8'hF1, 8'h0F, 4'd14, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4);
    step();
    req_valid = 1'b0;
    check_eq("wb_d0", 32'(mem_data), 32'hF1);
    check_eq("wb_a0", 32'(mem_addr), 32'd14);
    step();
    check_eq("wb_d1", 32'(mem_data), 32'h02);
    check_eq("wb_a1", 32'(mem_addr), 32'd15);
    step();
    check_eq("wb_d2", 32'(mem_data), 32'h13);
    check_eq("wb_a2", 32'(mem_addr), 32'd0);
    step();
    check_eq("wb_d3", 32'(mem_data), 32'h24);
    check_eq("wb_a3", 32'(mem_addr), 32'd1);
    step();
    check_eq("wb_gap", 32'(mem_mode), 32'd0);
    drain();

    // Compare burst wrapping data, then a zero-length fire.
    set_req(3'd4, 8'hFE, 8'hAA, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
    step();
    req_valid = 1'b0;
    check_eq("c_d0", 32'(mem_data), 32'hFE);
    check_eq("c_m0", 32'(mem_mode), 32'd4);
    step();
    check_eq("c_d1", 32'(mem_data), 32'hFF);
    step();
    check_eq("c_d2", 32'(mem_data), 32'h00);
    check_eq("c_m2", 32'(mem_mode), 32'd4);
    drain();
    set_req(3'd3, 8'h07, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    req_valid = 1'b0;
    check_eq("f_mode",  32'(mem_mode),  32'd3);
    check_eq("f_pktid", 32'(mem_pktid), 32'd7);
    step();
    check_eq("f_gap", 32'(mem_mode), 32'd0);
    drain();

    // Reset during the third beat of an 8-beat read burst.
    set_req(3'd2, 8'h00, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8);
    step();
    req_valid = 1'b0;
    step();
    step();
    check_eq("rr_beat3_addr", 32'(mem_addr), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rr_mode",  32'(mem_mode),  32'd0);
    check_eq("rr_ready", 32'(req_ready), 32'd1);
    check_eq("rr_rspv",  32'(rsp_valid), 32'd0);
    set_req(3'd1, 8'h5A, 8'hFF, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2);
    step();
    req_valid = 1'b0;
    check_eq("rr_next_mode", 32'(mem_mode), 32'd1);
    drain();

    // Random traffic, including junk requests while busy and occasional resets.
    for (int it = 0; it < 1500; it++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!cur_busy) begin
        set_req(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                5'($urandom_range(0, 6)));
        req_valid = ($urandom_range(0, 3) != 0);
      end else begin
        set_req(3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
        req_valid = 1'($urandom);
      end
      step();
    end
    rst = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tcam_cmd_sequencer.md
Name: tcam_cmd_sequencer

Overview:
Hardware command initiator for the TCAM memory block. It turns one high-level request (valid/ready) into the cycle-exact MODE/Data/Mask/Address/flag sequences the memory expects, including multi-cycle bursts with auto-increment. It captures read data into a response stream. It sits between the spike-routing controller and the TCAM memory, and replaces the bench-side write, read, compare, fire and reset stimulus with synthesizable logic.

Parameters:
AddressSize, 4, entry address width
Bits, 8, entry data/mask width
ID_Width, 4, packet ID width; Bits >= 2*ID_Width
LenWidth, 5, burst length field width
RdLat, 1, cycles from MODE_R issue to valid mem_rd_data (1..3)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_op  in  3  MODE_W=001, MODE_R=010, MODE_F=011, MODE_C=100, MODE_RST=101; others ignored
req_data  in  Bits  write/compare data; [ID_Width-1:0] = fire packet ID
req_mskb  in  Bits  mask
req_addr  in  AddressSize  start address
req_dcs  in  1  data(1)/care(0) select
req_vbe  in  1  valid-bit enable
req_vbi  in  1  valid-bit in
req_inc  in  1  write burst: increment ID fields per beat
req_len  in  LenWidth  beats; 0 treated as 1
mem_mode  out  3  MODE to memory; MODE_I=000 when idle
mem_data  out  Bits  Data_In
mem_mskb  out  Bits  Mskb_In
mem_addr  out  AddressSize  A_In
mem_dcs  out  1  Dcs_In
mem_vbe  out  1  Vbe_In
mem_vbi  out  1  Vbi_In
mem_pktid  out  ID_Width  PacketID_In
mem_rd_data  in  Bits  read data from memory
rsp_valid  out  1  one-cycle pulse per read beat
rsp_data  out  Bits  captured read data
busy  out  1  state != IDLE

Behaviour:
- All mem_* outputs, rsp_* and busy are registered. Reset values: mem_mode=000, all data/mask/address/pktid/flags 0, rsp_valid=0, rsp_data=0, busy=0, req_ready=1.
- FSM IDLE -> ISSUE -> GAP -> IDLE. Accept when req_valid&&req_ready; the request is latched and ISSUE starts on the next cycle.
- ISSUE: one cycle per beat, N = max(req_len,1). mem_mode=req_op. Fields are driven per op:
  - W: data, mskb, addr, dcs, vbe, vbi.
  - R: addr, dcs, vbe.
  - C: data, mskb.
  - F: pktid = req_data[ID_Width-1:0].
  - RST: pktid=0, N forced to 1.
- Per-beat updates after each beat:
  - addr+1, mod 2^AddressSize, wraps 15->0 silently (W, R).
  - C: data+1, mod 2^Bits.
  - F: pktid+1, mod 2^ID_Width.
  - W with inc=1: data[Bits-1:Bits-ID_Width]+1 and data[ID_Width-1:0]+1, each field wrapping independently. Middle bits unchanged.
- GAP: exactly one cycle after the last beat. mem_mode=MODE_I. data, mskb, addr, vbe and vbi are 0; dcs is held from the request; pktid is 0. Then IDLE; req_ready rises in the cycle after GAP.
- Back-to-back requests: minimum spacing N+2 cycles from accept to next accept.
- Read capture: for each R beat issued in cycle t, rsp_data = mem_rd_data sampled at t+RdLat and rsp_valid pulses in cycle t+RdLat+1. Pulses may extend past GAP; req_ready does not wait for them.
- Illegal req_op (000, 110, 111): the request is accepted and dropped. No ISSUE, no GAP, and the FSM stays in IDLE.
- rst mid-burst: on the next edge the FSM goes to IDLE and outputs return to reset values. Pending read pulses are discarded and the remaining beats are not issued.
- req fields are only sampled at accept; changes during busy are ignored.

Decomposition:
- Shared package tcam_pkg holds:
  - MODE_I/W/R/F/C/RST localparams and a mode_e enum.
  - An FSM state enum {IDLE, ISSUE, GAP}.
  - A helper function for the two-field ID increment.
- Sub-module tcam_rd_capture: RdLat-deep shift register of read-beat flags plus a data sample register, producing rsp_valid/rsp_data. It is cleared by rst.

Test Plan:
- Reset 3 cycles then release -> all mem_* = 0, mem_mode=000, req_ready=1, busy=0.
- W data=8'h00, mskb=8'hFF, addr=1, dcs=vbe=vbi=1, len=1 -> one cycle mode=001 with those values, then one cycle mode=000 with data/mskb/addr/vbe/vbi=0 and dcs=1, then req_ready=1.
- Same write followed by R addr=1, len=1, memory model RdLat=1 -> rsp_valid pulses once with rsp_data=8'h00 two cycles after the R issue cycle.
- W burst: data=8'hF1, addr=14, inc=1, len=4 -> addr 14,15,0,1; data F1, 02, 13, 24; then GAP.
- C burst: data=8'hFE, len=3 -> data FE, FF, 00, mode=100 for 3 cycles; F len=0 with pktid 7 -> a single beat with pktid 7.
- rst asserted during the 3rd beat of an 8-beat R burst -> next cycle all outputs at reset values, no further rsp_valid; a new request is accepted immediately afterward.
